// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module : instr_fetch_unit_if
// Brief  : Instruction-memory request/valid bus between fetch unit and memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Fetch stage; one outstanding imem request latched into the IR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         pc_in,
  input  logic               fetch_req,
  input  logic               flush,
  instr_fetch_unit_if.master imem,
  output logic [15:0]        ir_out,
  output logic               ir_valid,
  output logic               fetch_done,
  output logic               fetch_err,
  output logic               fetch_busy,
  output logic [3:0]         opcode,
  output logic [2:0]         ra,
  output logic [2:0]         rb,
  output logic [2:0]         rc,
  output logic [5:0]         imm6,
  output logic [8:0]         imm9
);

  localparam int unsigned     c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               req_q, req_d;
  logic [5:0]         addr_q, addr_d;
  logic [15:0]        ir_q, ir_d;
  logic               irv_q, irv_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  logic               w_timeout;
  logic [c_CNT_W-1:0] w_cnt_inc;

  // The cycle that would make the counter reach TIMEOUT is the last request cycle.
  assign w_timeout = (cnt_q == c_CNT_LAST);
  assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (!flush && fetch_req) state_d = c_WAIT;
      end
      c_WAIT: begin
        if (imem.imem_valid || w_timeout) state_d = c_IDLE;
        else if (flush)                   state_d = c_DRAIN;
      end
      c_DRAIN: begin
        if (imem.imem_valid || w_timeout) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    ir_d   = ir_q;
    irv_d  = irv_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    cnt_d  = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (flush) begin
          irv_d = 1'b0;
        end else if (fetch_req) begin
          addr_d = pc_in;
          req_d  = 1'b1;
          cnt_d  = '0;
        end
      end
      c_WAIT: begin
        if (imem.imem_valid) begin
          req_d = 1'b0;
          if (flush) begin
            irv_d = 1'b0;
          end else begin
            ir_d   = imem.imem_rdata;
            irv_d  = 1'b1;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = w_cnt_inc;
          if (w_timeout) begin
            req_d = 1'b0;
            err_d = 1'b1;
            irv_d = 1'b0;
          end else if (flush) begin
            irv_d = 1'b0;
          end
        end
      end
      c_DRAIN: begin
        if (imem.imem_valid) begin
          req_d = 1'b0;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_timeout) begin
            req_d = 1'b0;
            err_d = 1'b1;
            irv_d = 1'b0;
          end
        end
      end
      default: begin
        req_d = 1'b0;
        irv_d = 1'b0;
      end
    endcase
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign ir_out     = ir_q;
  assign ir_valid   = irv_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign fetch_busy = (state_q != c_IDLE);

  assign opcode = ir_q[15:12];
  assign ra     = ir_q[11:9];
  assign rb     = ir_q[8:6];
  assign rc     = ir_q[5:3];
  assign imm6   = ir_q[5:0];
  assign imm9   = ir_q[8:0];

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the multicycle CPU: takes the 6-bit program-counter value, runs a request/valid handshake with instruction memory, and latches the returned 16-bit word into the instruction register. It exposes decoded instruction fields to the controller and datapath, including the 6-bit immediate used as the PC branch offset. It also provides flush, for taken branches, and timeout handling. One fetch is outstanding at a time.

## Interface
- TIMEOUT, default 15: max cycles `imem_req` may stay high without `imem_valid`; range 1–255.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  6  current PC value from the program counter.
- fetch_req  input  1  controller request; sampled only in IDLE.
- flush  input  1  abort or invalidate the current instruction.
- imem_req  output  1  memory request; once raised, held until `imem_valid` or timeout.
- imem_addr  output  6  address latched from `pc_in` at fetch start; stable while `imem_req` is high.
- imem_rdata  input  16  instruction word; valid when `imem_valid` is high.
- imem_valid  input  1  one-cycle data-return strobe; ignored unless `imem_req` is high.
- ir_out  output  16  instruction register.
- ir_valid  output  1  `ir_out` holds a live, unflushed instruction.
- fetch_done  output  1  one-cycle pulse: IR updated on the preceding edge.
- fetch_err  output  1  one-cycle pulse: fetch abandoned on timeout.
- fetch_busy  output  1  high in WAIT or DRAIN.
- opcode  output  4  `ir_out[15:12]`.
- ra  output  3  `ir_out[11:9]`.
- rb  output  3  `ir_out[8:6]`.
- rc  output  3  `ir_out[5:3]`.
- imm6  output  6  `ir_out[5:0]`; feeds the PC offset input.
- imm9  output  9  `ir_out[8:0]`.

## Operation
- **States:** IDLE, WAIT, DRAIN. `fetch_busy` = (state != IDLE).
- **Reset:** state IDLE; all outputs 0 (`imem_req`, `imem_addr`, `ir_out`, `ir_valid`, `fetch_done`, `fetch_err`, timeout counter). Reset overrides everything, including mid-fetch. Memory must tolerate `imem_req` dropping on reset.
- **IDLE:**
  - `flush` clears `ir_valid`, and `fetch_req` is ignored that cycle (flush has priority).
  - Otherwise `fetch_req` latches `imem_addr <= pc_in`, sets `imem_req <= 1`, clears the counter, and goes to WAIT.
- **WAIT:**
  - Counter increments each cycle `imem_valid` is low.
  - `imem_valid`: `ir_out <= imem_rdata`, `ir_valid <= 1`, `imem_req <= 0`, `fetch_done` pulses next cycle, go IDLE.
  - `flush` without `imem_valid`: `ir_valid <= 0`, keep `imem_req` high, go DRAIN.
  - `flush` together with `imem_valid`: data discarded, `ir_out` unchanged, `ir_valid <= 0`, no `fetch_done`, go IDLE.
  - Counter reaching TIMEOUT without `imem_valid`: `imem_req <= 0`, `fetch_err` pulses, IR unchanged, `ir_valid <= 0`, go IDLE.
- **DRAIN:**
  - `imem_req` stays high until `imem_valid` arrives; the data is discarded and the state goes IDLE with no `fetch_done`.
  - Timeout applies exactly as in WAIT and also pulses `fetch_err`.
  - `flush` has no further effect.
- **Ignored inputs:** `fetch_req` is ignored outside IDLE. `pc_in` changes after fetch start do not affect `imem_addr`.
- **Decode outputs:** purely combinational from `ir_out`. They reflect `ir_out` even when `ir_valid` = 0.
- **Counter:** width `$clog2(TIMEOUT+1)`; saturates, no wrap.

## Timing
- **Zero-wait memory:**
  - `fetch_req` high in cycle 0.
  - `imem_req` and `imem_addr` valid from cycle 1.
  - `imem_valid` arrives in cycle 1.
  - `ir_out`, `ir_valid` and `fetch_done` are high in cycle 2.
  - Minimum fetch: 2 cycles request-to-IR.
- **Wait states:** N memory wait states give N+2 cycles.
- **Back-to-back:** earliest next `fetch_req` is accepted in the `fetch_done` cycle, giving a throughput of one fetch per 2 cycles.
- **Timeout:** with no `imem_valid`, `imem_req` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). `fetch_err` is high in cycle TIMEOUT+1, and `imem_req` is low in the same cycle.
- **Pulse width:** `fetch_done` and `fetch_err` are never high for more than one cycle and never high together.

## Test plan
1. **Reset and basic fetch.**
   - Stimulus: reset; `pc_in`=6'h05, `fetch_req` in cycle 0; memory returns 16'h3A47 in cycle 1.
   - Required: `imem_addr`=05 in cycle 1.
   - Required in cycle 2: `ir_out`=3A47, `fetch_done`=1, `opcode`=3, `ra`=5, `rb`=1, `rc`=0, `imm6`=07, `imm9`=047.
2. **Wait states plus ignored inputs.**
   - Stimulus: memory delays 3 cycles; `pc_in` changes and `fetch_req` re-pulses during WAIT.
   - Required: `imem_addr` stays at the original value; exactly one `fetch_done`, in cycle 5.
3. **Flush during WAIT.**
   - Stimulus: `flush` in cycle 2; data 16'hFFFF returns in cycle 4.
   - Required: `imem_req` high until cycle 4; `ir_out` unchanged; `ir_valid`=0; no `fetch_done`; `fetch_busy` low in cycle 5.
4. **Simultaneous flush and valid.**
   - Stimulus: `flush` and `imem_valid` in the same cycle.
   - Required: IR not updated, `ir_valid`=0, no `fetch_done`.
   - Stimulus: `flush` plus `fetch_req` in IDLE.
   - Required: no fetch started.
5. **Timeout.**
   - Stimulus: TIMEOUT=4; memory never responds.
   - Required: `imem_req` high in cycles 1–4; `fetch_err` in cycle 5; IR unchanged. A next fetch then succeeds normally.
6. **Reset mid-DRAIN.**
   - Stimulus: assert `rst` while in DRAIN.
   - Required: next cycle all outputs 0 and state IDLE; a late `imem_valid` is ignored.
